// File: rtl/cmd_frame_parser.sv
// UART command-frame parser: hunts SYNC, buffers one frame, checks CRC-8, then
// streams CMD/payload out as valid/ready beats with error pulses and statistics.
module cmd_frame_parser #(
    parameter int unsigned MAX_LEN     = 32,
    parameter logic [7:0]  SYNC_BYTE   = 8'hAA,
    parameter logic [7:0]  CRC_POLY    = 8'h07,
    parameter logic [7:0]  CRC_INIT    = 8'h00,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic        CLK,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  m_cmd,
    output logic [7:0]  m_len,
    output logic [7:0]  m_data,
    output logic        m_valid,
    output logic        m_last,
    input  logic        m_ready,
    output logic        frame_ok,
    output logic        err_crc,
    output logic        err_len,
    output logic        err_timeout,
    output logic        err_overrun,
    output logic        busy,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt
);
    localparam int unsigned DEPTH = (MAX_LEN > 2) ? MAX_LEN - 2 : 1;
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned TW    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    typedef enum logic [2:0] {S_IDLE, S_LEN, S_BODY, S_CHK, S_OUT} state_t;

    state_t        state_q;
    logic [7:0]    crc_q, len_q, cnt_q, cmd_q, idx_q;
    logic [TW-1:0] tmo_q;
    logic [7:0]    m_cmd_q, m_len_q, m_data_q;
    logic          m_valid_q, m_last_q;
    logic          frame_ok_q, err_crc_q, err_len_q, err_timeout_q, err_overrun_q;
    logic [15:0]   frame_cnt_q, err_cnt_q;
    logic [7:0]    buf_mem [DEPTH];

    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ CRC_POLY) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

    logic [7:0]    crc_d;
    logic          wr_en, len_ok, last_body, tmo_hit, any_err;
    logic [AW-1:0] wr_addr, rd_next;

    assign crc_d     = crc8_byte(crc_q, rx_data);
    assign wr_en     = rx_valid && (state_q == S_BODY) && (cnt_q != 8'd0);
    assign wr_addr   = AW'(cnt_q - 8'd1);
    assign rd_next   = AW'(idx_q + 8'd1);
    assign len_ok    = (rx_data >= 8'd2) && (rx_data <= 8'(MAX_LEN));
    assign last_body = (cnt_q == len_q - 8'd2);
    assign tmo_hit   = (TIMEOUT_CYC != 0) && (tmo_q == TW'(TIMEOUT_CYC - 1));
    assign any_err   = err_crc_q | err_len_q | err_timeout_q | err_overrun_q;

    // Payload buffer: written while receiving BODY, read into m_data_q during OUT.
    always_ff @(posedge CLK) begin
        if (wr_en) buf_mem[wr_addr] <= rx_data;
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            crc_q         <= CRC_INIT;
            len_q         <= 8'd0;
            cnt_q         <= 8'd0;
            cmd_q         <= 8'd0;
            idx_q         <= 8'd0;
            tmo_q         <= '0;
            m_cmd_q       <= 8'd0;
            m_len_q       <= 8'd0;
            m_data_q      <= 8'd0;
            m_valid_q     <= 1'b0;
            m_last_q      <= 1'b0;
            frame_ok_q    <= 1'b0;
            err_crc_q     <= 1'b0;
            err_len_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            err_overrun_q <= 1'b0;
            frame_cnt_q   <= 16'd0;
            err_cnt_q     <= 16'd0;
        end else begin
            frame_ok_q    <= 1'b0;
            err_crc_q     <= 1'b0;
            err_len_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            err_overrun_q <= 1'b0;
            if (frame_ok_q && frame_cnt_q != 16'hFFFF) frame_cnt_q <= frame_cnt_q + 16'd1;
            if (any_err && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
            if (rx_valid) tmo_q <= '0;

            case (state_q)
                S_IDLE: begin
                    if (rx_valid && rx_data == SYNC_BYTE) begin
                        state_q <= S_LEN;
                        crc_q   <= CRC_INIT;
                    end
                end
                S_OUT: begin
                    if (rx_valid) err_overrun_q <= 1'b1;
                    if (m_ready) begin
                        if (m_last_q) begin
                            m_valid_q <= 1'b0;
                            m_last_q  <= 1'b0;
                            state_q   <= S_IDLE;
                        end else begin
                            idx_q    <= idx_q + 8'd1;
                            m_data_q <= buf_mem[rd_next];
                            m_last_q <= (idx_q + 8'd2 == m_len_q);
                        end
                    end
                end
                default: begin
                    if (!rx_valid) begin
                        if (tmo_hit) begin
                            err_timeout_q <= 1'b1;
                            tmo_q         <= '0;
                            state_q       <= S_IDLE;
                        end else if (TIMEOUT_CYC != 0) begin
                            tmo_q <= tmo_q + 1'b1;
                        end
                    end else if (state_q == S_LEN) begin
                        if (len_ok) begin
                            len_q   <= rx_data;
                            crc_q   <= crc_d;
                            cnt_q   <= 8'd0;
                            state_q <= S_BODY;
                        end else begin
                            err_len_q <= 1'b1;
                            state_q   <= S_IDLE;
                        end
                    end else if (state_q == S_BODY) begin
                        crc_q <= crc_d;
                        if (cnt_q == 8'd0) cmd_q <= rx_data;
                        if (last_body) state_q <= S_CHK;
                        else           cnt_q   <= cnt_q + 8'd1;
                    end else begin
                        // CRC byte: on a match the first beat is presented immediately.
                        if (rx_data == crc_q) begin
                            frame_ok_q <= 1'b1;
                            state_q    <= S_OUT;
                            m_valid_q  <= 1'b1;
                            m_cmd_q    <= cmd_q;
                            m_len_q    <= len_q - 8'd2;
                            idx_q      <= 8'd0;
                            m_last_q   <= (len_q <= 8'd3);
                            m_data_q   <= (len_q == 8'd2) ? 8'h00 : buf_mem[{AW{1'b0}}];
                        end else begin
                            err_crc_q <= 1'b1;
                            state_q   <= S_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign m_cmd       = m_cmd_q;
    assign m_len       = m_len_q;
    assign m_data      = m_data_q;
    assign m_valid     = m_valid_q;
    assign m_last      = m_last_q;
    assign frame_ok    = frame_ok_q;
    assign err_crc     = err_crc_q;
    assign err_len     = err_len_q;
    assign err_timeout = err_timeout_q;
    assign err_overrun = err_overrun_q;
    assign busy        = (state_q != S_IDLE);
    assign frame_cnt   = frame_cnt_q;
    assign err_cnt     = err_cnt_q;
endmodule

// File: tb/tb_cmd_frame_parser.sv
// Directed bench for cmd_frame_parser: hand-built frames, beat/pulse monitor, scored checks.
module tb_cmd_frame_parser;
    localparam int TMO = 60;

    logic        CLK = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  m_cmd, m_len, m_data;
    logic        m_valid, m_last, m_ready;
    logic        frame_ok, err_crc, err_len, err_timeout, err_overrun, busy;
    logic [15:0] frame_cnt, err_cnt;

    always #5 CLK = ~CLK;

    cmd_frame_parser #(
        .MAX_LEN    (32),
        .SYNC_BYTE  (8'hAA),
        .CRC_POLY   (8'h07),
        .CRC_INIT   (8'h00),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .CLK        (CLK),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .m_cmd      (m_cmd),
        .m_len      (m_len),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_last     (m_last),
        .m_ready    (m_ready),
        .frame_ok   (frame_ok),
        .err_crc    (err_crc),
        .err_len    (err_len),
        .err_timeout(err_timeout),
        .err_overrun(err_overrun),
        .busy       (busy),
        .frame_cnt  (frame_cnt),
        .err_cnt    (err_cnt)
    );

    int checks = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    // Monitor: records every transferred beat and counts pulses.
    logic [7:0] beat_d[$];
    logic       beat_l[$];
    int n_ok = 0, n_crc = 0, n_len = 0, n_tmo = 0, n_ovr = 0;

    always @(negedge CLK) begin
        if (m_valid && m_ready) begin
            beat_d.push_back(m_data);
            beat_l.push_back(m_last);
        end
        if (frame_ok)    n_ok  <= n_ok + 1;
        if (err_crc)     n_crc <= n_crc + 1;
        if (err_len)     n_len <= n_len + 1;
        if (err_timeout) n_tmo <= n_tmo + 1;
        if (err_overrun) n_ovr <= n_ovr + 1;
    end

    logic [7:0] tx_q[$];
    logic [7:0] exp_q[$];

    // Sends tx_q one byte per cycle; entered and left at posedge+1.
    task automatic send_tx();
        foreach (tx_q[i]) begin
            rx_data  = tx_q[i];
            rx_valid = 1'b1;
            @(posedge CLK); #1;
        end
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic wait_idle(input string tag, input bit toggle);
        for (int i = 0; i < 400; i++) begin
            if (!busy && !m_valid) return;
            if (toggle) m_ready = ~m_ready;
            @(posedge CLK); #1;
        end
        check_val({tag, "_idle_bound"}, 32'(busy), 32'd0);
    endtask

    task automatic check_frame(input string tag, input int base, input logic [7:0] cmd,
                               input logic [7:0] mlen);
        int nb;
        int nlast;
        nb = exp_q.size();
        nlast = 0;
        check_val({tag, "_cmd"}, 32'(m_cmd), 32'(cmd));
        check_val({tag, "_len"}, 32'(m_len), 32'(mlen));
        check_val({tag, "_nbeats"}, 32'(beat_d.size() - base), 32'(nb));
        for (int i = 0; i < nb; i++) begin
            if (base + i < beat_d.size()) begin
                check_val($sformatf("%s_beat%0d", tag, i), 32'(beat_d[base + i]), 32'(exp_q[i]));
                if (beat_l[base + i]) nlast++;
            end
        end
        if (beat_d.size() > 0)
            check_val({tag, "_last_on_final"}, 32'(beat_l[beat_d.size() - 1]), 32'd1);
        check_val({tag, "_nlast"}, 32'(nlast), 32'd1);
    endtask

    task automatic load_edge_frame();
        tx_q = '{8'hAA, 8'h17, 8'h05, 8'h03, 8'h00, 8'h00, 8'h00, 8'h11, 8'h00, 8'h22,
                 8'h00, 8'h33, 8'h00, 8'h44, 8'h00, 8'h55, 8'h00, 8'h66, 8'h00, 8'h77,
                 8'h00, 8'h88, 8'h00, 8'h99, 8'h05};
        exp_q.delete();
        for (int i = 3; i < 24; i++) exp_q.push_back(tx_q[i]);
    endtask

    int base, snap, n;

    initial begin
        rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; m_ready = 1'b1;
        repeat (2) @(posedge CLK); #1;
        check_val("rst_m_valid", 32'(m_valid), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_m_cmd", 32'(m_cmd), 32'd0);
        check_val("rst_m_data", 32'(m_data), 32'd0);
        check_val("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check_val("rst_err_cnt", 32'(err_cnt), 32'd0);
        rst_n = 1'b1;
        @(posedge CLK); #1;

        // Swap frame, zero payload
        base = beat_d.size();
        tx_q = '{8'hAA, 8'h02, 8'h01, 8'h2D};
        send_tx();
        check_val("t1_frame_ok", 32'(frame_ok), 32'd1);
        check_val("t1_m_valid", 32'(m_valid), 32'd1);
        wait_idle("t1", 1'b0);
        exp_q = '{8'h00};
        check_frame("t1", base, 8'h01, 8'd0);
        check_val("t1_frame_cnt", 32'(frame_cnt), 32'd1);

        // Load-edge frame with m_ready toggling
        base = beat_d.size();
        load_edge_frame();
        m_ready = 1'b0;
        send_tx();
        wait_idle("t2", 1'b1);
        m_ready = 1'b1;
        check_frame("t2", base, 8'h05, 8'd21);
        check_val("t2_frame_cnt", 32'(frame_cnt), 32'd2);

        // Bad CRC then a good frame
        base = beat_d.size();
        tx_q = '{8'hAA, 8'h03, 8'h02, 8'h00, 8'h98};
        send_tx();
        check_val("t3_err_crc", 32'(err_crc), 32'd1);
        check_val("t3_no_valid", 32'(m_valid), 32'd0);
        repeat (3) @(posedge CLK); #1;
        check_val("t3_no_beats", 32'(beat_d.size() - base), 32'd0);
        check_val("t3_err_cnt", 32'(err_cnt), 32'd1);
        tx_q = '{8'hAA, 8'h02, 8'h07, 8'h3F};
        send_tx();
        wait_idle("t3b", 1'b0);
        exp_q = '{8'h00};
        check_frame("t3b", base, 8'h07, 8'd0);

        // Length errors, then a one-byte-payload frame
        tx_q = '{8'hAA, 8'h01};
        send_tx();
        check_val("t4_err_len_short", 32'(err_len), 32'd1);
        check_val("t4_idle_short", 32'(busy), 32'd0);
        tx_q = '{8'hAA, 8'h40};
        send_tx();
        check_val("t4_err_len_long", 32'(err_len), 32'd1);
        check_val("t4_idle_long", 32'(busy), 32'd0);
        base = beat_d.size();
        tx_q = '{8'hAA, 8'h03, 8'h02, 8'h00, 8'h97};
        send_tx();
        wait_idle("t4", 1'b0);
        exp_q = '{8'h00};
        check_frame("t4", base, 8'h02, 8'd1);
        check_val("t4_err_cnt", 32'(err_cnt), 32'd3);
        check_val("t4_frame_cnt", 32'(frame_cnt), 32'd4);

        // Inter-byte timeout
        tx_q = '{8'hAA, 8'h03, 8'h02};
        send_tx();
        n = 0;
        while (n < 3 * TMO && !err_timeout) begin
            @(posedge CLK); #1;
            n++;
        end
        check_val("t5_tmo_cycles", 32'(n), 32'(TMO));
        check_val("t5_tmo_busy", 32'(busy), 32'd0);
        @(posedge CLK); #1;
        check_val("t5_err_cnt", 32'(err_cnt), 32'd4);

        // Reset mid-BODY
        tx_q = '{8'hAA, 8'h05, 8'h03, 8'h11};
        send_tx();
        check_val("t5r_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("t5r_busy", 32'(busy), 32'd0);
        check_val("t5r_frame_cnt", 32'(frame_cnt), 32'd0);
        check_val("t5r_err_cnt", 32'(err_cnt), 32'd0);
        check_val("t5r_m_cmd", 32'(m_cmd), 32'd0);
        @(posedge CLK); #1;
        rst_n = 1'b1;
        @(posedge CLK); #1;
        base = beat_d.size();
        tx_q = '{8'hAA, 8'h02, 8'h01, 8'h2D};
        send_tx();
        wait_idle("t5r", 1'b0);
        exp_q = '{8'h00};
        check_frame("t5r", base, 8'h01, 8'd0);
        check_val("t5r_frame_cnt_after", 32'(frame_cnt), 32'd1);

        // Overrun while the output is stalled
        m_ready = 1'b0;
        base = beat_d.size();
        snap = n_ok;
        load_edge_frame();
        send_tx();
        tx_q = '{8'hAA, 8'h02, 8'h01, 8'h2D};
        n = n_ovr;
        send_tx();
        @(posedge CLK); #1;
        check_val("t6_overruns", 32'(n_ovr - n), 32'd4);
        check_val("t6_err_cnt", 32'(err_cnt), 32'd4);
        check_val("t6_still_valid", 32'(m_valid), 32'd1);
        m_ready = 1'b1;
        wait_idle("t6", 1'b0);
        check_val("t6_ok_pulses", 32'(n_ok - snap), 32'd1);
        load_edge_frame();
        check_frame("t6", base, 8'h05, 8'd21);
        check_val("t6_frame_cnt", 32'(frame_cnt), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cmd_frame_parser.md
Name: cmd_frame_parser

Overview:
- Parametrised UART command-frame parser between the UART RX byte stage and the command executor (clear/swap/status/load_edge handlers).
- Hunts SYNC, buffers one whole frame, checks CRC-8, then releases the command and payload as a valid/ready byte stream.
- Adds programmable frame size, CRC polynomial and inter-byte timeout, error pulses and saturating statistics counters.
- Frame on the wire: SYNC, LEN, CMD, PAYLOAD[LEN-2], CRC. LEN counts CMD through CRC inclusive. CRC covers LEN, CMD and PAYLOAD.

Parameters:
- MAX_LEN, 32: largest legal LEN value; payload buffer depth is MAX_LEN-2 bytes.
- SYNC_BYTE, 8'hAA: frame start marker.
- CRC_POLY, 8'h07: CRC-8 polynomial, MSB-first, no reflection, no final XOR.
- CRC_INIT, 8'h00: CRC seed.
- TIMEOUT_CYC, 100000: maximum idle CLK cycles between bytes inside a frame; 0 disables the timeout.

Ports:
- CLK in 1: system clock.
- rst_n in 1: asynchronous active-low reset.
- rx_data in 8: received byte.
- rx_valid in 1: one-cycle strobe qualifying rx_data; cannot be back-pressured.
- m_cmd out 8: CMD of the frame being output; stable for the whole frame.
- m_len out 8: payload byte count (LEN-2); stable for the whole frame.
- m_data out 8: payload byte.
- m_valid out 1: output beat valid.
- m_last out 1: final beat of the frame.
- m_ready in 1: sink ready.
- frame_ok out 1: one-cycle pulse when a good frame is accepted.
- err_crc out 1: one-cycle error pulse.
- err_len out 1: one-cycle error pulse.
- err_timeout out 1: one-cycle error pulse.
- err_overrun out 1: one-cycle error pulse.
- busy out 1: high in any state other than IDLE.
- frame_cnt out 16: good frames, saturating.
- err_cnt out 16: total error pulses, saturating.

Behaviour:
- Reset: every output is 0, state is IDLE, counters are 0, CRC register = CRC_INIT. An asserted reset mid-frame or mid-output discards everything.
- States: IDLE, LEN, BODY, CHK, OUT.
- IDLE: rx_valid with SYNC_BYTE moves to LEN and loads CRC := CRC_INIT. Any other byte is ignored silently.
- LEN: if LEN<2 or LEN>MAX_LEN, pulse err_len and go to IDLE. Otherwise latch LEN, update CRC, go to BODY. A LEN byte equal to SYNC_BYTE is treated as a length, not a resync.
- BODY: first byte is CMD; the remaining LEN-2 bytes are written to buffer[0..]. Every byte updates the CRC. After CMD plus LEN-2 payload bytes, go to CHK. SYNC_BYTE inside BODY is plain data.
- CRC update: one byte per rx_valid, combinational 8-step unroll, crc = (crc<<1) ^ (msb ? CRC_POLY : 0).
- CHK: the received byte is compared with the CRC register.
  - Match: frame_ok pulses the cycle after the CRC byte strobe; go to OUT with m_valid=1 that same cycle.
  - Mismatch: pulse err_crc, go to IDLE, m_valid never asserts.
- OUT:
  - Beats buffer[0..m_len-1]; m_last=1 on beat m_len-1.
  - If m_len=0, emit exactly one beat with m_data=8'h00 and m_last=1.
  - A beat transfers on m_valid & m_ready. m_data, m_last, m_cmd and m_len hold while m_valid & ~m_ready.
  - After the last transfer, m_valid drops next cycle and the state returns to IDLE.
  - Back-to-back frames: earliest m_valid of the next frame follows its CRC byte as above.
- Overrun: any rx_valid while in OUT drops that byte and pulses err_overrun, once per dropped byte. Buffer contents and output beats are unaffected.
- Timeout: the counter clears on every rx_valid and counts in LEN, BODY and CHK. Reaching TIMEOUT_CYC pulses err_timeout and returns to IDLE. The counter is inactive in IDLE and OUT.
- Counters:
  - frame_cnt increments on frame_ok.
  - err_cnt increments on any error pulse; each of the four pulses is mutually exclusive per cycle.
  - Both counters saturate at 16'hFFFF.
- busy is 1 in LEN, BODY, CHK and OUT.

Test Plan:
- Swap frame AA 02 01 2D, m_ready=1 → frame_ok; one beat m_cmd=01, m_len=0, m_data=00, m_last=1; frame_cnt=1.
- Load-edge frame AA 17 05 03 00 00 00 11 00 22 00 33 00 44 00 55 00 66 00 77 00 88 00 99 05, m_ready toggling every cycle → m_cmd=05, m_len=21; 21 beats 03,00,00,...,99 in order with none lost or duplicated; m_last only on the 0x99 beat.
- Bad CRC AA 03 02 00 98 (correct value 97) → err_crc pulse, no m_valid, err_cnt=1; a following AA 02 07 3F is accepted with m_cmd=07.
- AA 01 → err_len. AA 40 with MAX_LEN=32 → err_len. Both leave the parser in IDLE, and the next valid frame is accepted.
- AA 03 02, then no bytes for TIMEOUT_CYC cycles → err_timeout, busy=0. Separately, rst_n low mid-BODY → all outputs 0 and the next frame decodes normally.
- Hold m_ready=0 after a good frame and send AA 02 01 2D → 4 err_overrun pulses, err_cnt=4; release m_ready → the original frame's beats delivered intact.
